// File: rtl/syndrome_weight_arb_pkg.sv
// Shared definitions for the syndrome weight arbiter slice.
//   - CHUNK_W      : width of one popcount chunk (128 bits)
//   - DEF_NCHUNK   : default number of chunks per request vector
//   - state_t      : FSM state encoding (IDLE / ACC / DONE)
//   - vec_width    : request vector width for a given chunk count
//   - weight_width : result width able to hold 0..vec_width inclusive
package syndrome_weight_arb_pkg;

   localparam int CHUNK_W    = 128;
   localparam int DEF_NCHUNK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int vec_width(input int nchunk);
      return CHUNK_W * nchunk;
   endfunction

   function automatic int weight_width(input int nchunk);
      return $clog2(CHUNK_W * nchunk + 1);
   endfunction

endpackage

// File: rtl/syndrome_weight_arb_if.sv
// Handshake bundle for syndrome_weight_arb.
//   req0_*/req1_* : two requesters offering VW-bit vectors (valid/ready/data)
//   out_*         : result channel (valid/ready, weight, zero flag, owner tag)
//   busy          : arbiter is not idle
// Modports: slave = the arbiter, master = requesters plus result consumer.
interface syndrome_weight_arb_if
   import syndrome_weight_arb_pkg::*;
#(
   parameter int NCHUNK = DEF_NCHUNK,
   parameter int WW     = weight_width(NCHUNK)
);
   localparam int VW = vec_width(NCHUNK);

   logic          req0_valid;
   logic          req0_ready;
   logic [VW-1:0] req0_data;
   logic          req1_valid;
   logic          req1_ready;
   logic [VW-1:0] req1_data;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_weight;
   logic          out_zero;
   logic          out_tag;
   logic          busy;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_weight, out_zero, out_tag, busy
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input  req0_ready, req1_ready, out_valid, out_weight, out_zero, out_tag, busy
   );

endinterface

// File: rtl/bitsadder_128.sv
// Combinational population count of a 128-bit word.
//   data  : input word
//   count : number of ones in data (0..128)
module bitsadder_128 (
   input  logic [127:0] data,
   output logic [7:0]   count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 128; i++) begin
         count = count + 8'(data[i]);
      end
   end

endmodule

// File: rtl/syndrome_weight_arb.sv
// Two-requester round-robin arbiter that counts the ones in the granted
// vector, one 128-bit chunk per cycle, through a single shared popcount.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : syndrome_weight_arb_if.slave (request, result and busy signals)
// Timing: accept edge -> NCHUNK ACC edges -> DONE (out_valid high) ->
// output handshake edge -> IDLE; the next accept can follow one edge later.
module syndrome_weight_arb
   import syndrome_weight_arb_pkg::*;
#(
   parameter int NCHUNK = DEF_NCHUNK,
   parameter int WW     = weight_width(NCHUNK)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   syndrome_weight_arb_if.slave        bus
);

   localparam int VW = vec_width(NCHUNK);
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t        state_reg;
   logic [VW-1:0] vec_reg;
   logic [WW-1:0] acc_reg;
   logic [CW-1:0] cnt_reg;
   logic          last_grant_reg;
   logic          tag_reg;
   logic          out_valid_reg;
   logic [WW-1:0] out_weight_reg;
   logic          out_zero_reg;

   logic          grant;
   logic          accept;
   logic [CHUNK_W-1:0] chunk_arr [NCHUNK];
   logic [CHUNK_W-1:0] pop_in;
   logic [7:0]    pop_count;
   logic [WW-1:0] acc_next;
   logic          last_chunk;

   // Grant: on a tie pick the requester that did not win last time;
   // otherwise whichever one is valid (defaults to 1 only when req1 alone).
   always_comb begin
      grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_reg : bus.req1_valid;
      accept = (state_reg == IDLE) && (bus.req0_valid || bus.req1_valid);
   end

   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept &&  grant;

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign chunk_arr[gi] = vec_reg[gi*CHUNK_W +: CHUNK_W];
      end
   endgenerate

   // Popcount input is forced to zero outside ACC so the adder only ever
   // sees the captured vector while accumulating.
   always_comb begin
      pop_in = '0;
      if (state_reg == ACC) begin
         for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_reg == CW'(i)) begin
               pop_in = chunk_arr[i];
            end
         end
      end
   end

   bitsadder_128 u_popcnt (
      .data  (pop_in),
      .count (pop_count)
   );

   assign acc_next   = acc_reg + WW'(pop_count);
   assign last_chunk = (cnt_reg == CW'(NCHUNK - 1));

   // Captured vector needs no reset: it is only read after an accept loads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         vec_reg <= grant ? bus.req1_data : bus.req0_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
         tag_reg        <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_weight_reg <= '0;
         out_zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  tag_reg        <= grant;
                  last_grant_reg <= grant;
                  acc_reg        <= '0;
                  cnt_reg        <= '0;
                  state_reg      <= ACC;
               end
            end
            ACC: begin
               acc_reg <= acc_next;
               if (last_chunk) begin
                  cnt_reg        <= '0;
                  out_weight_reg <= acc_next;
                  out_zero_reg   <= (acc_next == '0);
                  out_valid_reg  <= 1'b1;
                  state_reg      <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.out_valid  = out_valid_reg;
   assign bus.out_weight = out_weight_reg;
   assign bus.out_zero   = out_zero_reg;
   assign bus.out_tag    = tag_reg;
   assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_syndrome_weight_arb.sv
// Directed bench for syndrome_weight_arb (NCHUNK=4, 512-bit vectors).
module tb_syndrome_weight_arb;
   import syndrome_weight_arb_pkg::*;

   localparam int NCHUNK = 4;
   localparam int WW     = 10;
   localparam int VW     = 512;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   syndrome_weight_arb_if #(.NCHUNK(NCHUNK), .WW(WW)) bus ();

   syndrome_weight_arb #(.NCHUNK(NCHUNK), .WW(WW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the DUT idle and out_ready high.
   task automatic run_req(input string tag, input bit who, input logic [VW-1:0] data,
                          input int exp_w);
      int lat;
      if (who) begin
         bus.req1_valid = 1'b1; bus.req1_data = data;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_data = data;
      end
      #1;
      chk({tag, "_rdy_own"},   32'(who ? bus.req1_ready : bus.req0_ready), 1);
      chk({tag, "_rdy_other"}, 32'(who ? bus.req0_ready : bus.req1_ready), 0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = ~data;   // post-accept changes must not matter
      bus.req1_data  = ~data;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 4);
      chk({tag, "_weight"},  32'(bus.out_weight), 32'(exp_w));
      chk({tag, "_zero"},    32'(bus.out_zero), 32'(exp_w == 0));
      chk({tag, "_tag"},     32'(bus.out_tag), 32'(who));
      $display("[TB] %s: req%0d weight=%0d zero=%0d tag=%0d latency=%0d",
               tag, who, bus.out_weight, bus.out_zero, bus.out_tag, lat);
      @(posedge clk); #1;
      chk({tag, "_drop_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_idle"},       32'(bus.busy), 0);
   endtask

   initial begin
      logic [VW-1:0] d0, d1, d;
      int gnt[$];
      int gcyc[$];
      int nres, cyc, nvalid;

      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_data  = '0;   bus.req1_data  = '0;
      bus.out_ready  = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid",  32'(bus.out_valid), 0);
      chk("rst_out_weight", 32'(bus.out_weight), 0);
      chk("rst_out_zero",   32'(bus.out_zero), 0);
      chk("rst_out_tag",    32'(bus.out_tag), 0);
      chk("rst_busy",       32'(bus.busy), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Both valid continuously: expect grants 0,1,0,1 spaced 6 cycles
      d0 = '0; d0[300] = 1'b1;
      d1 = '0; d1[10] = 1'b1; d1[200] = 1'b1; d1[450] = 1'b1;
      bus.req0_data = d0; bus.req1_data = d1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      nres = 0; cyc = 0;
      while (nres < 4 && cyc < 80) begin
         @(negedge clk); cyc++;
         if (bus.req0_ready) begin gnt.push_back(0); gcyc.push_back(cyc); end
         if (bus.req1_ready) begin gnt.push_back(1); gcyc.push_back(cyc); end
         if (bus.out_valid && bus.out_ready) begin
            chk("rr_weight", 32'(bus.out_weight), bus.out_tag ? 32'd3 : 32'd1);
            $display("[TB] rr result %0d: tag=%0d weight=%0d cycle=%0d",
                     nres, bus.out_tag, bus.out_weight, cyc);
            nres++;
         end
         if (gnt.size() >= 4 && (bus.req0_valid || bus.req1_valid)) begin
            @(posedge clk); #1;
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
         end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      chk("rr_results", 32'(nres), 4);
      chk("rr_grants",  32'(gnt.size()), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_grant%0d", k), (k < gnt.size()) ? 32'(gnt[k]) : 32'd99, 32'(k % 2));
      end
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("rr_spacing%0d", k),
             (k < gcyc.size()) ? 32'(gcyc[k] - gcyc[k-1]) : 32'd99, 6);
      end
      @(posedge clk); #1;

      // Single-requester vectors
      d = '1;
      run_req("ones_req0", 1'b0, d, 512);
      d = '0;
      run_req("zeros_req1", 1'b1, d, 0);
      d = '0; d[0] = 1'b1;
      run_req("bit0", 1'b0, d, 1);
      d = '0; d[511] = 1'b1;
      run_req("bit511", 1'b0, d, 1);
      d = '0; d[383:256] = '1;
      run_req("chunk2_ones", 1'b1, d, 128);
      d = {128'h0, 128'hFFFF_0000_0000_0000_0000_0000_0000_000F, 128'h0, 128'h1};
      run_req("sparse", 1'b1, d, 21);

      // Output stall: hold out_ready low for 10 cycles in DONE
      d = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0};
      bus.out_ready = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_data = d;
      #1;
      chk("stall_rdy1", 32'(bus.req1_ready), 1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_data = '1;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("stall_latency", 32'(cyc), 4);
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid",  32'(bus.out_valid), 1);
         chk("stall_weight", 32'(bus.out_weight), 256);
         chk("stall_tag",    32'(bus.out_tag), 1);
         chk("stall_busy",   32'(bus.busy), 1);
         chk("stall_rdy0",   32'(bus.req0_ready), 0);
         @(posedge clk); #1;
      end
      $display("[TB] stall: held 10 cycles weight=%0d tag=%0d", bus.out_weight, bus.out_tag);
      bus.req0_valid = 1'b0;
      bus.out_ready  = 1'b1;
      #1;
      chk("stall_release_valid", 32'(bus.out_valid), 1);
      @(posedge clk); #1;
      chk("stall_done_valid", 32'(bus.out_valid), 0);
      chk("stall_done_busy",  32'(bus.busy), 0);

      // Reset during ACC cycle 2, then a tie must go to req0
      d = '1;
      bus.req0_valid = 1'b1; bus.req0_data = d;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid",  32'(bus.out_valid), 0);
      chk("arst_out_weight", 32'(bus.out_weight), 0);
      chk("arst_out_zero",   32'(bus.out_zero), 0);
      chk("arst_out_tag",    32'(bus.out_tag), 0);
      chk("arst_busy",       32'(bus.busy), 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.out_valid) nvalid++;
      end
      chk("arst_no_result", 32'(nvalid), 0);
      @(posedge clk); #1;
      for (int k = 0; k < 16; k++) begin
         d0[k*32 +: 32] = $urandom;
         d1[k*32 +: 32] = $urandom;
      end
      bus.req0_data = d0; bus.req1_data = d1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      chk("arst_tie_rdy0", 32'(bus.req0_ready), 1);
      chk("arst_tie_rdy1", 32'(bus.req1_ready), 0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_data = ~d0;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("arst_latency", 32'(cyc), 4);
      chk("arst_weight",  32'(bus.out_weight), 32'($countones(d0)));
      chk("arst_tag",     32'(bus.out_tag), 0);
      $display("[TB] post-reset random: weight=%0d expected=%0d tag=%0d",
               bus.out_weight, $countones(d0), bus.out_tag);
      @(posedge clk); #1;
      chk("arst_idle", 32'(bus.busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/syndrome_weight_arb.md
SYNDROME_WEIGHT_ARB -- requirements
Module: syndrome_weight_arb

Interface
REQ-001 The block SHALL have parameter NCHUNK, default 4, meaning the number of 128-bit chunks per request vector (VW = 128*NCHUNK bits).
REQ-002 The block SHALL have parameter WW, default 10, meaning the weight output width, equal to clog2(VW+1).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0/1 offers a vector.
REQ-006 req0_ready / req1_ready  output  1 each  requester 0/1 vector accepted this cycle when valid&&ready.
REQ-007 req0_data / req1_data  input  VW each  bit vector whose ones are counted.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_weight  output  WW  number of ones in the granted vector.
REQ-011 out_zero  output  1  high when out_weight==0 (all checks satisfied).
REQ-012 out_tag  output  1  index of the requester that owns the result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-015 In IDLE, readies SHALL be driven combinationally from the grant; at most one ready is high per cycle; both are 0 outside IDLE.
REQ-016 If only one requester is valid in IDLE, it SHALL be granted.
REQ-017 If both are valid in IDLE, the requester not granted last SHALL be granted (round-robin); last_grant updates only on an accepted handshake.
REQ-018 On acceptance, the block SHALL register the vector and the tag, clear the accumulator and chunk counter, and go to ACC.
REQ-019 In each ACC cycle, the block SHALL add the popcount of chunk[cnt] (bits 128*cnt+127 : 128*cnt) from one shared combinational 128-bit popcount to the accumulator, then increment cnt.
REQ-020 On the ACC edge with cnt==NCHUNK-1, the block SHALL load out_weight and out_zero and go to DONE; out_valid is first high exactly NCHUNK cycles after the accept edge.
REQ-021 In DONE, out_valid SHALL stay high and out_weight, out_zero and out_tag SHALL stay stable until out_valid&&out_ready; that edge returns to IDLE with out_valid low.
REQ-022 The block SHALL not accept a new request in the same cycle as the output handshake; the minimum request-to-request spacing is NCHUNK+2 cycles.
REQ-023 The accumulator SHALL be WW bits wide and never overflow; the maximum value is VW (512 for the default).
REQ-024 Input data changes after acceptance SHALL not affect the result.
REQ-025 The popcount SHALL only be in the datapath during ACC; no other path shares it.

Reset
REQ-026 Assertion of rst_n low SHALL immediately force: IDLE, out_valid=0, out_weight=0, out_zero=0, out_tag=0, busy=0, cnt=0, accumulator=0, and last_grant=1 (so requester 0 wins the first tie).
REQ-027 Reset mid-ACC or in DONE SHALL discard the in-flight result; no output handshake occurs for it.
REQ-028 Deassertion of reset SHALL give normal operation on the first following rising edge.

Structure
REQ-029 The state encoding, VW/WW derivation and the chunk width (128) SHALL live in a shared package used by the decoder blocks.
REQ-030 The design SHALL contain exactly one sub-module: the existing bitsadder_128, instantiated once.
REQ-031 Chunk selection SHALL be an NCHUNK:1 mux of 128-bit slices of the captured vector.

Verification
REQ-032 req0 only, data all-ones (512 bits) -> out_valid 4 cycles after accept, out_weight=512, out_zero=0, out_tag=0.
REQ-033 req1 only, data all-zeros -> out_weight=0, out_zero=1, out_tag=1.
REQ-034 Both valid continuously, out_ready=1 -> grants alternate 0,1,0,1; the first grant is 0; each request is spaced 6 cycles apart.
REQ-035 Single one at bit 0 and at bit 511 (two requests) -> out_weight=1 each; this confirms the first and last chunk mapping.
REQ-036 out_ready held low 10 cycles in DONE -> out_valid/weight/tag stable, readies low, busy high; release -> IDLE next edge.
REQ-037 rst_n pulsed low during ACC cycle 2 -> outputs zero immediately, no out_valid; the next request is granted to req0 and counted correctly (random vector vs. reference model).
